// File: rtl/pito_irq_ctrl.sv
// Machine-mode interrupt controller and trap scheduler for the barrel core.
// Optional 64-bit mtime/mtimecmp timer is built when PITO_IRQ_TIMER_EN is defined.
//
// state   | meaning
// IDLE    | no trap pending, round-robin search for an eligible hart
// REQ     | trap_hart/trap_cause committed, waiting for trap_ack
module pito_irq_ctrl #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      mvu_irq,
  input  logic [NUM_HARTS-1:0]      ext_irq,
  input  logic                      csr_we,
  input  logic [HART_CNT_WIDTH-1:0] csr_hart,
  input  logic [11:0]               csr_addr,
  input  logic [31:0]               csr_wdata,
  output logic [31:0]               csr_rdata,
  output logic                      trap_valid,
  output logic [HART_CNT_WIDTH-1:0] trap_hart,
  output logic [31:0]               trap_cause,
  input  logic                      trap_ack,
  input  logic                      mret_valid,
  input  logic [HART_CNT_WIDTH-1:0] mret_hart
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MTCMP_LO = 12'h7C0;
  localparam logic [11:0] CSR_MTCMP_HI = 12'h7C1;
  localparam logic [11:0] CSR_MTIME_LO = 12'h7C2;
  localparam logic [11:0] CSR_MTIME_HI = 12'h7C3;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MVU = 32'h8000_0010;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t state_q, state_d;

  logic [NUM_HARTS-1:0] mie_mvi, mie_mei, mie_mti, mie_msi;
  logic [NUM_HARTS-1:0] mvip, meip_q, mtip, msip;
  logic [NUM_HARTS-1:0] gie, in_trap;
  logic [NUM_HARTS-1:0] pend_mvi, pend_mei, pend_mti, pend_msi, eligible;
  logic [NUM_HARTS-1:0] csr_sel, ack_sel, mret_sel;

  logic [HART_CNT_WIDTH-1:0] rr_ptr, rr_d;
  logic [HART_CNT_WIDTH-1:0] trap_hart_d, sel_hart;
  logic [31:0]               trap_cause_d;
  logic                      sel_found, ack_fire;

  function automatic logic [31:0] cause_of(input logic mei, input logic msi,
                                           input logic mti, input logic mvi);
    if (mei)      return CAUSE_MEI;
    else if (msi) return CAUSE_MSI;
    else if (mti) return CAUSE_MTI;
    else if (mvi) return CAUSE_MVU;
    else          return 32'h0;
  endfunction

  assign ack_fire   = (state_q == ST_REQ) && trap_ack;
  assign trap_valid = (state_q == ST_REQ);

  always_comb begin
    csr_sel  = '0;
    ack_sel  = '0;
    mret_sel = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      csr_sel[h] = csr_we && (csr_hart == HART_CNT_WIDTH'(h));
      ack_sel[h] = ack_fire && (trap_hart == HART_CNT_WIDTH'(h));
    end
    // An MRET racing the ack of the same hart is dropped; the hart stays in trap.
    for (int h = 0; h < NUM_HARTS; h++)
      mret_sel[h] = mret_valid && (mret_hart == HART_CNT_WIDTH'(h)) && !ack_sel[h];
  end

  assign pend_mvi = mvip   & mie_mvi;
  assign pend_mei = meip_q & mie_mei;
  assign pend_mti = mtip   & mie_mti;
  assign pend_msi = msip   & mie_msi;
  assign eligible = gie & ~in_trap & (pend_mvi | pend_mei | pend_mti | pend_msi);

`ifdef PITO_IRQ_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp [NUM_HARTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      mtime <= mtime + 64'd1;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (csr_sel[h] && csr_addr == CSR_MTCMP_LO) mtimecmp[h][31:0]  <= csr_wdata;
        if (csr_sel[h] && csr_addr == CSR_MTCMP_HI) mtimecmp[h][63:32] <= csr_wdata;
      end
    end
  end

  always_comb begin
    mtip = '0;
    for (int h = 0; h < NUM_HARTS; h++) mtip[h] = (mtime >= mtimecmp[h]);
  end
`else
  assign mtip = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_mvi <= '0;
      mie_mei <= '0;
      mie_mti <= '0;
      mie_msi <= '0;
      mvip    <= '0;
      meip_q  <= '0;
      msip    <= '0;
      gie     <= '0;
      in_trap <= '0;
    end else begin
      meip_q <= ext_irq;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (csr_sel[h]) begin
          case (csr_addr)
            CSR_MIE: begin
              mie_mvi[h] <= csr_wdata[16];
              mie_mei[h] <= csr_wdata[11];
              mie_mti[h] <= csr_wdata[7];
              mie_msi[h] <= csr_wdata[3];
            end
            CSR_MIP: begin
              msip[h] <= csr_wdata[3];
              if (!csr_wdata[16]) mvip[h] <= 1'b0;
            end
            CSR_MSTATUS: gie[h] <= csr_wdata[3];
            default: ;
          endcase
        end
        if (mret_sel[h]) begin
          in_trap[h] <= 1'b0;
          gie[h]     <= 1'b1;
        end
        // Later assignments win: ack overrides a same-cycle gie write, MVU pulse overrides clears.
        if (ack_sel[h]) begin
          in_trap[h] <= 1'b1;
          gie[h]     <= 1'b0;
          if (trap_cause == CAUSE_MVU) mvip[h] <= 1'b0;
        end
        if (mvu_irq[h]) mvip[h] <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_hart  = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!sel_found && eligible[(int'(rr_ptr) + i) % NUM_HARTS]) begin
        sel_found = 1'b1;
        sel_hart  = HART_CNT_WIDTH'((int'(rr_ptr) + i) % NUM_HARTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      trap_hart  <= '0;
      trap_cause <= '0;
      rr_ptr     <= '0;
    end else begin
      state_q    <= state_d;
      trap_hart  <= trap_hart_d;
      trap_cause <= trap_cause_d;
      rr_ptr     <= rr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    trap_hart_d  = trap_hart;
    trap_cause_d = trap_cause;
    rr_d         = rr_ptr;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d      = ST_REQ;
          trap_hart_d  = sel_hart;
          trap_cause_d = cause_of(pend_mei[sel_hart], pend_msi[sel_hart],
                                  pend_mti[sel_hart], pend_mvi[sel_hart]);
        end
      end
      ST_REQ: begin
        if (trap_ack) begin
          state_d = ST_IDLE;
          rr_d    = (trap_hart == HART_CNT_WIDTH'(NUM_HARTS - 1)) ? '0
                                                                  : trap_hart + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MIE: begin
        csr_rdata[16] = mie_mvi[csr_hart];
        csr_rdata[11] = mie_mei[csr_hart];
        csr_rdata[7]  = mie_mti[csr_hart];
        csr_rdata[3]  = mie_msi[csr_hart];
      end
      CSR_MIP: begin
        csr_rdata[16] = mvip[csr_hart];
        csr_rdata[11] = meip_q[csr_hart];
        csr_rdata[7]  = mtip[csr_hart];
        csr_rdata[3]  = msip[csr_hart];
      end
      CSR_MSTATUS: csr_rdata[3] = gie[csr_hart];
`ifdef PITO_IRQ_TIMER_EN
      CSR_MTCMP_LO: csr_rdata = mtimecmp[csr_hart][31:0];
      CSR_MTCMP_HI: csr_rdata = mtimecmp[csr_hart][63:32];
      CSR_MTIME_LO: csr_rdata = mtime[31:0];
      CSR_MTIME_HI: csr_rdata = mtime[63:32];
`endif
      default: csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pito_irq_ctrl.sv
// Directed self-checking bench for pito_irq_ctrl: CSR access, cause priority,
// round-robin order, committed requests, timer gating and async reset.
module tb_pito_irq_ctrl;
  localparam int NH = 8;
  localparam int HW = 3;

  logic          clk, rst_n;
  logic [NH-1:0] mvu_irq, ext_irq;
  logic          csr_we;
  logic [HW-1:0] csr_hart;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata, csr_rdata;
  logic          trap_valid;
  logic [HW-1:0] trap_hart;
  logic [31:0]   trap_cause;
  logic          trap_ack, mret_valid;
  logic [HW-1:0] mret_hart;

  int n_cmp = 0;
  int n_err = 0;

  pito_irq_ctrl #(.NUM_HARTS(NH), .HART_CNT_WIDTH(HW)) dut (
    .clk(clk), .rst_n(rst_n), .mvu_irq(mvu_irq), .ext_irq(ext_irq),
    .csr_we(csr_we), .csr_hart(csr_hart), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap_valid(trap_valid),
    .trap_hart(trap_hart), .trap_cause(trap_cause), .trap_ack(trap_ack),
    .mret_valid(mret_valid), .mret_hart(mret_hart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input int h, input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_hart = HW'(h); csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input int h, input logic [11:0] a, output logic [31:0] d);
    csr_hart = HW'(h); csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic ack();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
  endtask

  task automatic mret(input int h);
    mret_valid = 1'b1; mret_hart = HW'(h);
    step();
    mret_valid = 1'b0;
  endtask

  task automatic expect_trap(input string tag, input int h, input logic [31:0] cause);
    check({tag, "_valid"}, {31'd0, trap_valid}, 32'd1);
    check({tag, "_hart"},  {29'd0, trap_hart}, 32'(h));
    check({tag, "_cause"}, trap_cause, cause);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int waited;
    rst_n = 1'b0; mvu_irq = '0; ext_irq = '0; csr_we = 1'b0; csr_hart = '0;
    csr_addr = '0; csr_wdata = '0; trap_ack = 1'b0; mret_valid = 1'b0; mret_hart = '0;
    do_reset();

    check("rst_valid", {31'd0, trap_valid}, 32'd0);
    check("rst_hart", {29'd0, trap_hart}, 32'd0);
    check("rst_cause", trap_cause, 32'd0);
    csr_read(0, 12'h304, rd); check("rst_mie", rd, 32'd0);
    csr_read(0, 12'h344, rd); check("rst_mip", rd, 32'd0);
    csr_read(0, 12'h300, rd); check("rst_mstatus", rd, 32'd0);

    // Hart 2 MVU interrupt
    csr_write(2, 12'h304, 32'hFFFF_FFFF & 32'h0001_0000);
    csr_write(2, 12'h300, 32'h0000_0008);
    csr_read(2, 12'h304, rd); check("h2_mie", rd, 32'h0001_0000);
    mvu_irq[2] = 1'b1;
    step();
    mvu_irq[2] = 1'b0;
    check("h2_lat_k", {31'd0, trap_valid}, 32'd0);
    csr_read(2, 12'h344, rd); check("h2_mvip_set", rd, 32'h0001_0000);
    step();
    expect_trap("h2", 2, 32'h8000_0010);
    ack();
    check("h2_ack_valid", {31'd0, trap_valid}, 32'd0);
    csr_read(2, 12'h344, rd); check("h2_mvip_clr", rd, 32'd0);
    csr_read(2, 12'h300, rd); check("h2_gie_clr", rd, 32'd0);
    mret(2);
    csr_read(2, 12'h300, rd); check("h2_gie_mret", rd, 32'h8);
    step();
    check("h2_no_retrap", {31'd0, trap_valid}, 32'd0);

    // Hart 5: MEI beats MSI, then MSI after MRET
    csr_write(5, 12'h304, 32'h0000_0808);
    csr_write(5, 12'h344, 32'h0000_0008);
    ext_irq[5] = 1'b1;
    csr_write(5, 12'h300, 32'h0000_0008);
    step();
    expect_trap("h5_mei", 5, 32'h8000_000B);
    ext_irq[5] = 1'b0;
    ack();
    mret(5);
    step();
    expect_trap("h5_msi", 5, 32'h8000_0003);
    ack();
    csr_write(5, 12'h344, 32'h0);
    mret(5);
    step();
    check("h5_quiet", {31'd0, trap_valid}, 32'd0);

    // Round robin among harts 0, 3, 7
    do_reset();
    csr_write(0, 12'h304, 32'h8); csr_write(0, 12'h344, 32'h8);
    csr_write(3, 12'h304, 32'h8); csr_write(3, 12'h344, 32'h8);
    csr_write(7, 12'h304, 32'h8); csr_write(7, 12'h344, 32'h8);
    csr_write(0, 12'h300, 32'h8);
    csr_write(3, 12'h300, 32'h8);
    csr_write(7, 12'h300, 32'h8);
    expect_trap("rr_first", 0, 32'h8000_0003);
    ack();
    check("rr_gap", {31'd0, trap_valid}, 32'd0);
    step();
    expect_trap("rr_second", 3, 32'h8000_0003);
    ack();
    step();
    expect_trap("rr_third", 7, 32'h8000_0003);
    ack();
    repeat (3) step();
    check("rr_all_in_trap", {31'd0, trap_valid}, 32'd0);
    // Harts 0 and 7 become eligible together: pointer must have wrapped to 0
    csr_write(0, 12'h304, 32'h0); csr_write(7, 12'h304, 32'h0);
    mret(0); mret(7);
    csr_write(0, 12'h304, 32'h800); csr_write(7, 12'h304, 32'h800);
    check("rr_idle_pre_ext", {31'd0, trap_valid}, 32'd0);
    ext_irq = 8'h81;
    step();
    step();
    expect_trap("rr_wrap", 0, 32'h8000_000B);
    ack();
    step();
    expect_trap("rr_wrap_next", 7, 32'h8000_000B);
    ext_irq = '0;
    ack();
    repeat (2) step();
    check("rr_h3_blocked", {31'd0, trap_valid}, 32'd0);
    mret(3);
    step();
    expect_trap("rr_h3_again", 3, 32'h8000_0003);
    ack();

    // Committed request survives source drop and mie clear
    do_reset();
    ext_irq[1] = 1'b1;
    csr_write(1, 12'h304, 32'h800);
    csr_write(1, 12'h300, 32'h8);
    step();
    expect_trap("commit_pre", 1, 32'h8000_000B);
    ext_irq[1] = 1'b0;
    csr_write(1, 12'h304, 32'h0);
    csr_write(1, 12'h300, 32'h0);
    step();
    expect_trap("commit_hold", 1, 32'h8000_000B);
    // Ack beats a same-cycle gie write and MRET on the same hart
    trap_ack = 1'b1; csr_we = 1'b1; csr_hart = 3'd1; csr_addr = 12'h300; csr_wdata = 32'h8;
    mret_valid = 1'b1; mret_hart = 3'd1;
    step();
    trap_ack = 1'b0; csr_we = 1'b0; mret_valid = 1'b0;
    csr_read(1, 12'h300, rd); check("ack_beats_gie", rd, 32'd0);
    check("commit_acked", {31'd0, trap_valid}, 32'd0);

    // Timer on hart 1
    do_reset();
    csr_write(1, 12'h7C0, 32'd20);
    csr_write(1, 12'h7C1, 32'd0);
    csr_write(1, 12'h304, 32'h80);
    csr_write(1, 12'h300, 32'h8);
`ifdef PITO_IRQ_TIMER_EN
    csr_read(1, 12'h7C0, rd); check("tmr_cmp_rd", rd, 32'd20);
    waited = 0;
    while (!trap_valid && waited < 100) begin step(); waited++; end
    check("tmr_wait", {31'd0, trap_valid}, 32'd1);
    expect_trap("tmr", 1, 32'h8000_0007);
    ack();
`else
    csr_read(1, 12'h7C0, rd); check("tmr_cmp_rd", rd, 32'd0);
    waited = 0;
    while (!trap_valid && waited < 60) begin step(); waited++; end
    check("tmr_no_trap", {31'd0, trap_valid}, 32'd0);
    csr_read(1, 12'h344, rd); check("tmr_mtip_zero", rd, 32'd0);
`endif

    // Asynchronous reset during REQ
    do_reset();
    ext_irq[4] = 1'b1;
    csr_write(4, 12'h304, 32'h800);
    csr_write(4, 12'h300, 32'h8);
    step();
    expect_trap("arst_pre", 4, 32'h8000_000B);
    ext_irq = '0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, trap_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    csr_read(4, 12'h304, rd); check("arst_mie", rd, 32'd0);
    csr_read(4, 12'h344, rd); check("arst_mip", rd, 32'd0);
    csr_read(4, 12'h300, rd); check("arst_mstatus", rd, 32'd0);
    check("arst_cause", trap_cause, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
